// File: rtl/hcsr04_emulator_pkg.sv
// Shared types and default timing for the HC-SR04 responder emulator.
// width_t is also used by the distance front-end for echo widths in microseconds.
package hcsr04_pkg;

  localparam int CLK_PER_US_DEF  = 40;
  localparam int MIN_TRIG_US_DEF = 10;
  localparam int BURST_US_DEF    = 200;
  localparam int TIMEOUT_US_DEF  = 38000;
  localparam int HOLDOFF_US_DEF  = 2000;

  typedef logic [15:0] width_t;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HIGH,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  localparam width_t LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic width_t lfsr_next(input width_t v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Requested width -> legal echo width: no object or oversize gives the timeout,
  // zero is stretched to 1 us so the driver always sees a pulse.
  function automatic width_t clamp_width(input width_t req, input logic obj,
                                         input width_t limit);
    if (!obj)         return limit;
    if (req == '0)    return width_t'(1);
    if (req > limit)  return limit;
    return req;
  endfunction

endpackage

// File: rtl/hcsr04_emulator_us_tick.sv
// Microsecond prescaler: one-cycle tick every CLK_PER_US clocks, restartable
// by a synchronous clear so each FSM phase starts on an exact cycle boundary.
module us_tick
  import hcsr04_pkg::*;
#(
  parameter int CLK_PER_US = CLK_PER_US_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

  logic [CW-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     cnt <= '0;
    else if (clear || cnt == LAST) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

  // Not masked by clear: the trigger-width check needs the tick that lands
  // in the same cycle the phase ends.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/hcsr04_emulator.sv
// HC-SR04 responder emulator: validates trig, waits the burst delay, then drives
// echo for the programmed width. Define HCSR04_EMU_JITTER_EN to add 0-7 us LFSR jitter.
module hcsr04_emulator
  import hcsr04_pkg::*;
#(
  parameter int CLK_PER_US  = CLK_PER_US_DEF,
  parameter int MIN_TRIG_US = MIN_TRIG_US_DEF,
  parameter int BURST_US    = BURST_US_DEF,
  parameter int TIMEOUT_US  = TIMEOUT_US_DEF,
  parameter int HOLDOFF_US  = HOLDOFF_US_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   trig,
  input  width_t echo_us,
  input  logic   obj_present,
  output logic   echo,
  output logic   busy,
  output logic   trig_err
);

  localparam width_t MIN_TRIG   = width_t'(MIN_TRIG_US);
  localparam width_t BURST_LAST = width_t'(BURST_US - 1);
  localparam width_t HOLD_LAST  = width_t'(HOLDOFF_US - 1);
  localparam width_t TIMEOUT_W  = width_t'(TIMEOUT_US);

  // [0],[1] form the synchronizer; [2] is the delayed copy for edge detection.
  logic [2:0] trig_sync;
  logic       trig_rise, trig_fall;

  state_t state, state_n;
  width_t us_cnt, us_now;
  width_t width, width_n;
  width_t width_req, width_lat;
  logic   tick, phase_clear, accept, err_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) trig_sync <= '0;
    else       trig_sync <= {trig_sync[1:0], trig};
  end

  assign trig_rise = trig_sync[1] & ~trig_sync[2];
  assign trig_fall = ~trig_sync[1] & trig_sync[2];

  us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (phase_clear),
    .tick  (tick)
  );

  // Count including the current tick, saturating at all-ones.
  assign us_now = (tick && us_cnt != '1) ? us_cnt + 1'b1 : us_cnt;

  assign accept    = (state == TRIG_HIGH) && trig_fall && (us_now >= MIN_TRIG);
  assign width_req = clamp_width(echo_us, obj_present, TIMEOUT_W);

`ifdef HCSR04_EMU_JITTER_EN
  width_t      lfsr;
  logic [16:0] jit_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       lfsr <= LFSR_SEED;
    else if (accept) lfsr <= lfsr_next(lfsr);
  end

  assign jit_sum   = {1'b0, width_req} + {14'b0, lfsr[2:0]};
  assign width_lat = (jit_sum > {1'b0, TIMEOUT_W}) ? TIMEOUT_W : jit_sum[15:0];
`else
  assign width_lat = width_req;
`endif

  // NOTE: every output of this block gets a default first; otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_n = state;
    width_n = width;
    err_n   = 1'b0;
    case (state)
      IDLE:      if (trig_rise) state_n = TRIG_HIGH;
      TRIG_HIGH: begin
        if (accept) begin
          state_n = BURST;
          width_n = width_lat;
        end else if (trig_fall) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      BURST:     if (tick && us_cnt == BURST_LAST)   state_n = ECHO;
      ECHO:      if (tick && us_cnt == width - 1'b1) state_n = HOLDOFF;
      HOLDOFF:   if (tick && us_cnt == HOLD_LAST)    state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Restart both the prescaler and the us counter on every state entry.
  assign phase_clear = (state_n != state);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      us_cnt   <= '0;
      width    <= '0;
      echo     <= 1'b0;
      busy     <= 1'b0;
      trig_err <= 1'b0;
    end else begin
      state    <= state_n;
      us_cnt   <= phase_clear ? '0 : us_now;
      width    <= width_n;
      echo     <= (state_n == ECHO);
      busy     <= (state_n == BURST) || (state_n == ECHO) || (state_n == HOLDOFF);
      trig_err <= err_n;
    end
  end

endmodule

// File: tb/tb_hcsr04_emulator.sv
// Scoreboard bench for hcsr04_emulator with shortened timing parameters.
// Stimulus pushes expected echo/trig_err events; a negedge monitor pops and checks them.
module tb_hcsr04_emulator;

  localparam int CPU  = 4;
  localparam int MIN  = 10;
  localparam int BUR  = 20;
  localparam int TO   = 100;
  localparam int HOLD = 30;

  logic        clk = 1'b0;
  logic        reset, trig, obj_present;
  logic [15:0] echo_us;
  logic        echo, busy, trig_err;

  hcsr04_emulator #(
    .CLK_PER_US (CPU),
    .MIN_TRIG_US(MIN),
    .BURST_US   (BUR),
    .TIMEOUT_US (TO),
    .HOLDOFF_US (HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trig       (trig),
    .echo_us    (echo_us),
    .obj_present(obj_present),
    .echo       (echo),
    .busy       (busy),
    .trig_err   (trig_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {EV_ECHO, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       t0;     // expected cycle of echo rise / trig_err rise
    int       width;  // expected pulse width in clk cycles
  } exp_t;

  typedef struct {
    int hi;   // trig high time in clk cycles
    int eu;
    bit obj;
    bit ok;
    int w_us; // expected width before jitter
  } vec_t;

  exp_t        q[$];
  vec_t        vecs[9];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] lfsr_m = 16'hACE1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares DUT output events against the scoreboard queue.
  bit   pe = 0, pb = 0, perr = 0;
  int   rise_c = 0, fall_c = 0, err_c = 0;
  exp_t e;

  always @(negedge clk) begin
    if (reset) begin
      pe = 0; pb = 0; perr = 0;
    end else begin
      if (echo && !pe) begin
        check("echo_rise_expected", (q.size() > 0 && q[0].kind == EV_ECHO), 1);
        rise_c = cyc;
      end
      if (!echo && pe) fall_c = cyc;
      if (busy && !pb)
        check("busy_rise_expected", (q.size() > 0 && q[0].kind == EV_ECHO), 1);
      if (trig_err && !perr) begin
        check("trig_err_expected", (q.size() > 0 && q[0].kind == EV_ERR), 1);
        err_c = cyc;
      end
      if (!trig_err && perr) begin
        if (q.size() == 0) check("trig_err_queue", q.size(), 1);
        else begin
          e = q.pop_front();
          check("trig_err_time", err_c, e.t0);
          check("trig_err_width", cyc - err_c, e.width);
        end
      end
      if (!busy && pb) begin
        if (q.size() == 0) check("busy_fall_queue", q.size(), 1);
        else begin
          e = q.pop_front();
          check("echo_rise_time", rise_c, e.t0);
          check("echo_width", fall_c - rise_c, e.width);
          check("holdoff_len", cyc - fall_c, HOLD * CPU);
        end
      end
      pe = echo; pb = busy; perr = trig_err;
    end
  end

  task automatic pulse(input int hi, input int eu, input bit obj, input bit ok, input int w_us);
    exp_t x;
    int   w;
    @(posedge clk); #1;
    echo_us     = 16'(eu);
    obj_present = obj;
    trig        = 1'b1;
    repeat (hi) @(posedge clk);
    #1 trig = 1'b0;
    w = w_us;
    if (ok) begin
`ifdef HCSR04_EMU_JITTER_EN
      w = w_us + int'(lfsr_m[2:0]);
      if (w > TO) w = TO;
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
      x = '{EV_ECHO, cyc + 3 + BUR * CPU, w * CPU};
    end else begin
      x = '{EV_ERR, cyc + 3, 1};
    end
    q.push_back(x);
  endtask

  // Raw trig pulse with no expected response.
  task automatic stray_trig(input int hi);
    @(posedge clk); #1 trig = 1'b1;
    repeat (hi) @(posedge clk);
    #1 trig = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) check({name, "_timeout"}, n, 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_echo(input logic lvl, input string name);
    int n = 0;
    while (echo !== lvl && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) check({name, "_timeout"}, n, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{80,   50, 1'b1, 1'b1,  50},  // nominal
      '{20,   50, 1'b1, 1'b0,   0},  // 5 us trig rejected
      '{80,   25, 1'b0, 1'b1, 100},  // no object -> timeout
      '{80, 5000, 1'b1, 1'b1, 100},  // oversize clamped
      '{80,    0, 1'b1, 1'b1,   1},  // zero -> 1 us
      '{80,  100, 1'b1, 1'b1, 100},  // exactly timeout
      '{80,  101, 1'b1, 1'b1, 100},  // timeout + 1
      '{40,    7, 1'b1, 1'b1,   7},  // trig exactly MIN us
      '{39,    7, 1'b1, 1'b0,   0}   // one clock short of MIN
    };

    reset = 1'b1; trig = 1'b0; echo_us = '0; obj_present = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_echo", echo, 0);
    check("reset_busy", busy, 0);
    check("reset_trig_err", trig_err, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);

    foreach (vecs[i]) begin
      pulse(vecs[i].hi, vecs[i].eu, vecs[i].obj, vecs[i].ok, vecs[i].w_us);
      wait_done("vector");
    end

    // Retrigger during ECHO and during HOLDOFF: ignored.
    pulse(80, 50, 1'b1, 1'b1, 50);
    wait_echo(1'b1, "retrig_rise");
    repeat (10) @(posedge clk);
    stray_trig(80);
    wait_echo(1'b0, "retrig_fall");
    repeat (5) @(posedge clk);
    stray_trig(80);
    wait_done("retrig");

    // trig rises late in HOLDOFF and is still high when IDLE is entered.
    pulse(80, 50, 1'b1, 1'b1, 50);
    wait_echo(1'b0, "straddle_fall");
    repeat (100) @(posedge clk);
    stray_trig(80);
    repeat (30) @(posedge clk);
    wait_done("straddle");

    pulse(80, 30, 1'b1, 1'b1, 30);
    wait_done("after_busy");

    // Reset 15 us into a 50 us echo.
    pulse(80, 50, 1'b1, 1'b1, 50);
    wait_echo(1'b1, "mid_reset_rise");
    repeat (15 * CPU) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_reset_echo", echo, 0);
    check("mid_reset_busy", busy, 0);
    q.delete();
    lfsr_m = 16'hACE1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    pulse(80, 50, 1'b1, 1'b1, 50);
    wait_done("post_reset");

    // Back-to-back triggers; widths follow the jitter model when enabled.
    repeat (8) begin
      pulse(80, 50, 1'b1, 1'b1, 50);
      wait_done("jitter");
    end

    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hcsr04_emulator.md
Name: hcsr04_emulator

Overview:
Emulates the responder side of an HC-SR04 ultrasonic ranger, so the distance front-end can be exercised on the bench and in simulation without a physical sensor.
- Watches the trig line for a valid trigger pulse.
- Waits a fixed burst delay.
- Drives echo high for a programmable number of microseconds that encodes target distance.
- Sits beside the distance front-end on the 40 MHz fabric clock; a switch or SPI register supplies the echo width.

Parameters:
CLK_PER_US, 40, fabric clock cycles per microsecond
MIN_TRIG_US, 10, minimum trig high time accepted as a valid trigger
BURST_US, 200, delay from trig fall to echo rise (emulated 8-cycle 40 kHz burst)
TIMEOUT_US, 38000, echo width when no object is present; also the maximum echo width
HOLDOFF_US, 2000, dead time after echo falls before a new trigger is accepted

Ports:
clk  input  1  fabric clock, 40 MHz
reset  input  1  asynchronous, active-high
trig  input  1  trigger from the ranger driver (asynchronous to clk)
echo_us  input  16  desired echo width in us; sampled at trig fall
obj_present  input  1  0 = no object; forces a TIMEOUT_US echo
echo  output  1  echo pulse to the ranger driver
busy  output  1  high from accepted trig fall through end of HOLDOFF
trig_err  output  1  one-cycle pulse when a trig pulse shorter than MIN_TRIG_US is rejected

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk.
- Reset values: echo=0, busy=0, trig_err=0, state=IDLE, all counters 0. LFSR (if enabled) = 16'hACE1.
- Reset mid-operation forces echo low immediately, without waiting for a clock edge.
- Input sync: trig passes through a 2-flop synchronizer, then rise/fall edge detection. All timing below is relative to the synchronized edge.
- Microsecond tick: a prescaler emits one-cycle us_tick every CLK_PER_US cycles. It is cleared on every state entry, so each phase duration is exact in clk cycles.
- IDLE: busy=0.
  - Synchronized trig rise -> TRIG_HIGH; clear the us counter.
- TRIG_HIGH: the us counter increments on each us_tick.
  - On trig fall with count >= MIN_TRIG_US: latch width, set busy, go to BURST.
  - On trig fall with count < MIN_TRIG_US: pulse trig_err for 1 cycle, return to IDLE.
  - The counter saturates and does not wrap.
- Width latch rules:
  - obj_present=0 -> width=TIMEOUT_US.
  - echo_us=0 -> width=1.
  - echo_us>TIMEOUT_US -> width=TIMEOUT_US.
  - Otherwise width=echo_us.
- BURST: after exactly BURST_US us_ticks, go to ECHO. echo rises in the same cycle as the state change (registered output).
- ECHO: echo=1 for exactly width*CLK_PER_US clk cycles, then echo=0 and go to HOLDOFF.
- HOLDOFF: after HOLDOFF_US us_ticks, go to IDLE and clear busy.
- Retrigger handling: trig edges seen in BURST, ECHO or HOLDOFF are ignored; no retrigger and no trig_err.
  - If trig is still high when IDLE is entered, it is not a trigger. A fresh synchronized rise is required.
- Simultaneous events: reset dominates everything. A trig rise in the same cycle as HOLDOFF->IDLE is ignored.
- Widths: counters are 16 bits, and all comparisons are unsigned.

Optional Feature:
Macro: HCSR04_EMU_JITTER_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances once per accepted trigger.
  - lfsr[2:0] us is added to the latched width, clamped to TIMEOUT_US.
  - This models sensor jitter of 0-7 us.
- Undefined: no LFSR is instantiated and echo width is exactly the latched width.

Decomposition:
- Package hcsr04_pkg holds:
  - the state enum (IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF);
  - the default timing constants;
  - the 16-bit width type, shared with the distance front-end.
- Sub-module us_tick: a prescaler with a synchronous clear input and a one-cycle tick output, parameterized by CLK_PER_US.

Test Plan:
- Valid trigger: trig high 20 us, echo_us=1000, obj_present=1 -> echo rises 200 us after trig fall (plus 3 clk sync latency), stays high exactly 40000 clk; busy clears 2000 us after echo falls.
- Short trigger: trig high 5 us -> trig_err pulses exactly 1 cycle, echo stays 0, busy stays 0.
- Clamping and no-object cases:
  - obj_present=0, echo_us=500 -> echo width 38000 us.
  - echo_us=50000 -> echo width 38000 us.
  - echo_us=0 -> echo width 1 us.
- Retrigger immunity: a second 20 us trig during ECHO and during HOLDOFF -> no change to echo timing and no second echo. A new trig after busy falls produces a normal echo.
- Reset mid-echo: assert reset 300 us into a 1000 us echo -> echo 0 immediately, busy 0. After release, the next valid trig produces a full-width echo.
- With HCSR04_EMU_JITTER_EN: 8 back-to-back triggers with echo_us=1000 -> widths in [1000,1007] us matching the LFSR reference model sequence.
